// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding constants and types for the instruction encoder and
// the immediate decoder that reads its output.
package instruction_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R       = 3'b000,
        FMT_I       = 3'b001,
        FMT_S       = 3'b010,
        FMT_B       = 3'b011,
        FMT_U       = 3'b100,
        FMT_J       = 3'b101,
        FMT_RSVD    = 3'b110,
        FMT_ILLEGAL = 3'b111
    } format_e;

    // addi x0, x0, 0 -- substituted for any request that cannot be encoded
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
    localparam logic signed [63:0] IMM13_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM13_MAX =  64'sd4094;
    localparam logic signed [63:0] IMM21_MIN = -64'sd1048576;
    localparam logic signed [63:0] IMM21_MAX =  64'sd1048574;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } fifo_entry_t;

    function automatic logic imm_in_range(
        input logic signed [63:0] value,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/instruction_encoder_imm_packer.sv
// Combinational RV32I field packer with per-format immediate range checking;
// unencodable requests come out as a NOP with err set.
module imm_packer #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      format,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] immediate,
    output logic [31:0]     instr,
    output logic            err
);
    import instruction_encoder_pkg::*;

    logic signed [63:0] imm_s;
    logic [31:0]        packed_word;
    logic               legal;

    // Widen once so every range check is a plain signed compare whatever XLEN is
    assign imm_s = 64'(signed'(immediate));

    always_comb begin
        packed_word = NOP_INSTR;
        legal       = 1'b0;
        case (format_e'(format))
            FMT_R: begin
                packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
                legal       = 1'b1;
            end
            FMT_I: begin
                packed_word = {imm_s[11:0], rs1, funct3, rd, opcode};
                legal       = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                packed_word = {imm_s[11:5], rs2, rs1, funct3, imm_s[4:0], opcode};
                legal       = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                packed_word = {imm_s[12], imm_s[10:5], rs2, rs1, funct3,
                               imm_s[4:1], imm_s[11], opcode};
                legal       = imm_in_range(imm_s, IMM13_MIN, IMM13_MAX) && !imm_s[0];
            end
            FMT_U: begin
                packed_word = {imm_s[31:12], rd, opcode};
                legal       = (imm_s[11:0] == 12'd0);
            end
            FMT_J: begin
                packed_word = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], rd, opcode};
                legal       = imm_in_range(imm_s, IMM21_MIN, IMM21_MAX) && !imm_s[0];
            end
            default: begin
                packed_word = NOP_INSTR;
                legal       = 1'b0;
            end
        endcase
    end

    assign instr = legal ? packed_word : NOP_INSTR;
    assign err   = ~legal;

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs request fields, buffers {instruction, error}
// in a 2-entry FIFO and hands words out with a running instruction address.
module instruction_encoder #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      format,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] immediate,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     instruction_out,
    output logic [31:0]     out_address,
    output logic            out_error,
    output logic [7:0]      error_count
);
    import instruction_encoder_pkg::*;

    logic [31:0] enc_instr;
    logic        enc_err;

    imm_packer #(
        .XLEN(XLEN)
    ) u_imm_packer (
        .format    (format),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .immediate (immediate),
        .instr     (enc_instr),
        .err       (enc_err)
    );

    occ_e        occ_q, occ_d;
    fifo_entry_t mem_q [2];
    fifo_entry_t mem_d [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_address_q, out_address_d;
    logic [7:0]  error_count_q, error_count_d;

    logic        accept;
    logic        deliver;
    fifo_entry_t head_entry;

    // in_ready is a flop, so accept never looks at out_ready combinationally
    assign accept     = in_valid & in_ready_q;
    assign deliver    = out_valid_q & out_ready;
    assign head_entry = mem_q[head_q];

    always_comb begin
        occ_d         = occ_q;
        mem_d         = mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        out_address_d = out_address_q;
        error_count_d = error_count_q;

        case (occ_q)
            OCC_EMPTY: if (accept) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (accept && !deliver)      occ_d = OCC_FULL;
                else if (deliver && !accept) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (deliver) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase

        if (accept) begin
            mem_d[tail_q] = '{instr: enc_instr, err: enc_err};
            tail_d        = ~tail_q;
        end

        if (deliver) begin
            head_d        = ~head_q;
            out_address_d = out_address_q + 32'd4;
            if (head_entry.err && (error_count_q != 8'hFF)) begin
                error_count_d = error_count_q + 8'd1;
            end
        end

        in_ready_d  = (occ_d != OCC_FULL);
        out_valid_d = (occ_d != OCC_EMPTY);
    end

    // Reset clears the storage too, so instruction_out reads zero while held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q         <= OCC_EMPTY;
            mem_q[0]      <= '0;
            mem_q[1]      <= '0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_address_q <= BASE_ADDR;
            error_count_q <= 8'd0;
        end else begin
            occ_q         <= occ_d;
            mem_q         <= mem_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_address_q <= out_address_d;
            error_count_q <= error_count_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign instruction_out = head_entry.instr;
    assign out_error       = head_entry.err;
    assign out_address     = out_address_q;
    assign error_count     = error_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed RV32I cases, back-pressure,
// mid-transfer reset and randomized traffic against an arithmetic reference model.
module tb_instruction_encoder;

    localparam logic [31:0] TB_BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [31:0] out_address;
    logic        out_error;
    logic [7:0]  error_count;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] sb [$];
    logic [31:0] expAddr;
    int          expCnt;

    instruction_encoder #(
        .XLEN      (32),
        .BASE_ADDR (TB_BASE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .format          (format),
        .opcode          (opcode),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .funct3          (funct3),
        .funct7          (funct7),
        .immediate       (immediate),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .instruction_out (instruction_out),
        .out_address     (out_address),
        .out_error       (out_error),
        .error_count     (error_count)
    );

    always #5 clk = ~clk;

    // Reference encoding built from field weights and integer division, returns {err, word}
    function automatic logic [32:0] refEncode(
        input logic [2:0]  fmt,
        input logic [6:0]  opc,
        input logic [4:0]  rdV,
        input logic [4:0]  rs1V,
        input logic [4:0]  rs2V,
        input logic [2:0]  f3V,
        input logic [6:0]  f7V,
        input logic [31:0] imm
    );
        longint v, u, w, common, rdTerm;
        bit     ok;
        v      = longint'($signed(imm));
        common = longint'(rs2V) * 1048576 + longint'(rs1V) * 32768 + longint'(f3V) * 4096;
        rdTerm = longint'(rdV) * 128 + longint'(opc);
        ok     = 1'b1;
        w      = 0;
        case (fmt)
            3'd0: w = longint'(f7V) * 33554432 + common + rdTerm;
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                u  = v & 64'hFFF;
                w  = u * 1048576 + longint'(rs1V) * 32768 + longint'(f3V) * 4096 + rdTerm;
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                u  = v & 64'hFFF;
                w  = (u / 32) * 33554432 + common + (u % 32) * 128 + longint'(opc);
            end
            3'd3: begin
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                u  = v & 64'h1FFF;
                w  = (u / 4096) * 64'd2147483648 + ((u / 32) % 64) * 33554432 + common
                   + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + longint'(opc);
            end
            3'd4: begin
                ok = ((v & 64'hFFF) == 0);
                w  = (longint'(imm) / 4096) * 4096 + rdTerm;
            end
            3'd5: begin
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                u  = v & 64'h1FFFFF;
                w  = (u / 1048576) * 64'd2147483648 + ((u / 2) % 1024) * 2097152
                   + ((u / 2048) % 2) * 1048576 + ((u / 4096) % 256) * 4096 + rdTerm;
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, 32'(w)} : {1'b1, 32'h0000_0013};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic        v,
        input logic [2:0]  f,
        input logic [6:0]  o,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3v,
        input logic [6:0]  f7v,
        input logic [31:0] imm
    );
        in_valid  = v;
        format    = f;
        opcode    = o;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        funct3    = f3v;
        funct7    = f7v;
        immediate = imm;
    endtask

    // One clock: check handshakes against the scoreboard, then advance
    task automatic stepCycle();
        logic acc, dlv;
        checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        acc = in_valid & in_ready;
        dlv = out_valid & out_ready;
        if (dlv === 1'b1 && sb.size() > 0) begin
            checkOutput("deliver_instr", instruction_out, sb[0][31:0]);
            checkOutput("deliver_error", 32'(out_error), 32'(sb[0][32]));
            checkOutput("deliver_addr", out_address, expAddr);
            if (sb[0][32] && expCnt < 255) expCnt++;
            void'(sb.pop_front());
            expAddr += 32'd4;
        end
        if (acc === 1'b1 && sb.size() < 2) begin
            sb.push_back(refEncode(format, opcode, rd, rs1, rs2, funct3, funct7, immediate));
        end
        @(posedge clk);
        #1;
        checkOutput("error_count", 32'(error_count), 32'(expCnt));
    endtask

    task automatic directedCheck(
        input string       tag,
        input logic [2:0]  f,
        input logic [6:0]  o,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3v,
        input logic [31:0] imm,
        input logic [31:0] expInstr,
        input logic        expErr,
        input logic [31:0] expAddrC
    );
        out_ready = 1'b0;
        applyStimulus(1'b1, f, o, d, s1, s2, f3v, 7'd0, imm);
        stepCycle();
        in_valid = 1'b0;
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_instr"}, instruction_out, expInstr);
        checkOutput({tag, "_err"}, 32'(out_error), 32'(expErr));
        checkOutput({tag, "_addr"}, out_address, expAddrC);
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
    endtask

    initial begin
        int          edges [16];
        int          idx;
        int          nd;
        logic        accepted;
        logic [31:0] bpBase;
        logic [31:0] imm;

        edges = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                  3, -1048577, -1048576, 1048574, 1048575, 32'h1234_5000, 32'h1234_5001, 0};

        applyStimulus(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        out_ready = 1'b0;
        reset_n   = 1'b1;
        expAddr   = TB_BASE;
        expCnt    = 0;

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_instr", instruction_out, 32'd0);
        checkOutput("reset_out_error", 32'(out_error), 32'd0);
        checkOutput("reset_addr", out_address, TB_BASE);
        checkOutput("reset_err_count", 32'(error_count), 32'd0);
        reset_n = 1'b1;

        $display("[TB] directed encodings");
        directedCheck("i_type", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5,
                      32'h0050_0093, 1'b0, 32'hFFFF_FFF0);
        directedCheck("b_type", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4,
                      32'hFE20_8EE3, 1'b0, 32'hFFFF_FFF4);
        directedCheck("s_type", 3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8,
                      32'h0020_A423, 1'b0, 32'hFFFF_FFF8);
        directedCheck("j_type", 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,
                      32'h0010_00EF, 1'b0, 32'hFFFF_FFFC);
        directedCheck("u_type_wrap", 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000,
                      32'h1234_52B7, 1'b0, 32'h0000_0000);
        directedCheck("i_range_err", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,
                      32'h0000_0013, 1'b1, 32'h0000_0004);
        directedCheck("b_odd_err", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3,
                      32'h0000_0013, 1'b1, 32'h0000_0008);
        checkOutput("error_count_two", 32'(error_count), 32'd2);

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        idx       = 0;
        bpBase    = expAddr;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 3'd1, 7'b0010011, 5'(idx + 3), 5'd2, 5'd0, 3'd0, 7'd0,
                          32'(100 * (idx + 1)));
            accepted = in_ready;
            stepCycle();
            if (accepted === 1'b1) idx++;
            if (sb.size() > 0) begin
                checkOutput("bp_hold_instr", instruction_out, sb[0][31:0]);
                checkOutput("bp_hold_addr", out_address, bpBase);
            end
        end
        checkOutput("bp_accepts", 32'(idx), 32'd2);
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        nd        = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 3) begin
                applyStimulus(1'b1, 3'd1, 7'b0010011, 5'(idx + 3), 5'd2, 5'd0, 3'd0, 7'd0,
                              32'(100 * (idx + 1)));
            end else begin
                in_valid = 1'b0;
            end
            accepted = in_valid & in_ready;
            if (out_valid === 1'b1) begin
                checkOutput("bp_order_addr", out_address, bpBase + 32'(4 * nd));
                nd++;
            end
            stepCycle();
            if (accepted === 1'b1) idx++;
        end
        checkOutput("bp_delivered", 32'(nd), 32'd3);
        out_ready = 1'b0;

        $display("[TB] reset with FIFO full");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 3'd0, 7'b0110011, 5'(c + 7), 5'd3, 5'd4, 3'd0, 7'd32, 32'd0);
            stepCycle();
        end
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_instr", instruction_out, 32'd0);
        checkOutput("midreset_addr", out_address, TB_BASE);
        checkOutput("midreset_err_count", 32'(error_count), 32'd0);
        sb.delete();
        expAddr = TB_BASE;
        expCnt  = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        directedCheck("post_reset", 3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5,
                      32'h0050_0093, 1'b0, TB_BASE);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 300; c++) begin
            case ($urandom_range(0, 3))
                0:       imm = 32'(edges[$urandom_range(0, 15)]);
                1:       imm = $urandom;
                2:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom),
                          5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
            out_ready = 1'($urandom_range(0, 1));
            stepCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) stepCycle();
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the immediate input width.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the first out_address value after reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the encoder accepts a request this cycle.
REQ-007 The module SHALL have port format, input, 3 bits, coded R=000, I=001, S=010, B=011, U=100, J=101, ILLEGAL=111; 110 is also illegal.
REQ-008 The module SHALL have port opcode, input, 7 bits: placed in instruction bits [6:0].
REQ-009 The module SHALL have ports rd, rs1 and rs2, input, 5 bits each: register fields.
REQ-010 The module SHALL have port funct3, input, 3 bits, and port funct7, input, 7 bits: function fields.
REQ-011 The module SHALL have port immediate, input, XLEN bits: the signed byte-offset or value to pack.
REQ-012 The module SHALL have port out_valid, output, 1 bit: an encoded word is presented.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the consumer takes the word.
REQ-014 The module SHALL have port instruction_out, output, 32 bits: the encoded instruction.
REQ-015 The module SHALL have port out_address, output, 32 bits: the instruction-memory address for instruction_out.
REQ-016 The module SHALL have port out_error, output, 1 bit: the presented word replaced an unencodable request.
REQ-017 The module SHALL have port error_count, output, 8 bits: saturating count of errored words delivered.

Function
REQ-018 Packing SHALL be the exact inverse of RV32I immediate decoding:
- R: funct7|rs2|rs1|funct3|rd|opcode.
- I: imm[11:0]|rs1|funct3|rd|opcode.
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
- U: imm[31:12]|rd|opcode.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-019 Range checks SHALL be applied per format:
- I and S: -2048..2047.
- B: -4096..4094 and even.
- J: -1048576..1048574 and even.
- U: imm[11:0] must be zero.
- R: immediate is ignored.
REQ-020 An illegal format or a failed range check SHALL produce instruction_out=32'h0000_0013 (NOP) with out_error=1.
REQ-021 Requests SHALL be buffered in a 2-entry FIFO of {instruction, error}; encoding and checking happen before the FIFO write.
REQ-022 in_ready SHALL be driven from a register and SHALL equal "FIFO not full"; it SHALL have no combinational dependence on out_ready.
REQ-023 A request SHALL be accepted when in_valid and in_ready are both high; when accepted into an empty FIFO, out_valid SHALL rise on the next cycle (latency 1).
REQ-024 A word SHALL be delivered when out_valid and out_ready are both high; the FIFO then pops and out_address increments by 4.
REQ-025 out_address SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-026 Simultaneous accept and deliver SHALL keep occupancy unchanged; accept is allowed when full only if not registered-ready, i.e. never.
REQ-027 While out_valid=1 and out_ready=0, instruction_out, out_error and out_address SHALL hold stable.
REQ-028 error_count SHALL increment on each delivered word with out_error=1 and SHALL saturate at 255.
REQ-029 Occupancy SHALL follow the states EMPTY, ONE and FULL, with these transitions:
- EMPTY to ONE on accept.
- ONE to FULL on accept without deliver.
- ONE to EMPTY on deliver without accept.
- FULL to ONE on deliver.

Reset
REQ-030 While reset_n=0, the FIFO SHALL be emptied and the module SHALL drive out_valid=0, in_ready=1, instruction_out=0, out_error=0, out_address=BASE_ADDR and error_count=0.
REQ-031 Reset asserted mid-transfer SHALL discard buffered words; the first delivery after reset SHALL use out_address=BASE_ADDR.

Structure
REQ-032 The format codes, the NOP constant and the RV32I opcode constants SHALL live in the shared package used by the immediate decoder.
REQ-033 Combinational packing plus range checking SHALL be a sub-module, imm_packer; the FIFO, handshake and counters SHALL be in the top level.

Verification
REQ-034 The bench SHALL cover an I-type request: opcode 0010011, rd=1, rs1=0, funct3=0, immediate=5 -> 0x00500093 at out_address=BASE_ADDR, out_error=0.
REQ-035 The bench SHALL cover a B-type request: opcode 1100011, rs1=1, rs2=2, funct3=0, immediate=-4 -> 0xFE208EE3; and an S-type request: opcode 0100011, rs1=1, rs2=2, funct3=010, immediate=8 -> 0x0020A423.
REQ-036 The bench SHALL cover a J-type request: opcode 1101111, rd=1, immediate=2048 -> 0x001000EF; and a U-type request: opcode 0110111, rd=5, immediate=0x12345000 -> 0x123452B7.
REQ-037 The bench SHALL cover errors: an I-type request with immediate=2048 and a B-type request with immediate=3 -> each 0x00000013 with out_error=1, and error_count=2 after both are delivered.
REQ-038 The bench SHALL cover back-pressure: out_ready=0 for 5 cycles with 3 requests offered -> in_ready=0 after 2 accepts, outputs held stable; on release, words are delivered in order at addresses +0, +4, +8.
REQ-039 The bench SHALL cover reset: reset_n pulsed low with the FIFO FULL -> out_valid=0 and in_ready=1 immediately; the next delivery uses out_address=BASE_ADDR.
